keypad_letter_entry: RTL and testbench
======================================

# keypad_letter_entry

Upstream input stage of the hangman game: scans one 4x3 matrix keypad, debounces it, and turns multi-tap presses (phone style) into ASCII letters. It emits one-cycle strobes for "letter submitted" and "word submitted" to the game/host logic. One instance per keypad: host and player.

## Interface
- `SCAN_CYCLES`, default 4: cycles each column is driven while scanning idle keys.
- `DEBOUNCE_CYCLES`, default 1000: consecutive stable cycles needed for a press, and again for a release.
- `clk`  in  1: system clock.
- `nRst`  in  1: reset. One clock; reset is asynchronous and active-low.
- `row`  in  4: keypad rows, active-high; bit 3 = R0 … bit 0 = R3, so `4'b1000` = R0.
- `col`  out  3: column drive, one-hot, active-high; bit 0 = C0.
- `cur_letter`  out  8: ASCII of the letter currently being selected; `8'h00` when none.
- `letter_valid`  out  1: high while `cur_letter` holds a selection.
- `letter_strobe`  out  1: one-cycle pulse; `cur_letter` is valid in the same cycle.
- `word_strobe`  out  1: one-cycle pulse.
- `error`  out  1: one-cycle pulse on an illegal submit.

## Operation
- Key map (row,col):
  - R0C0: unused.
  - R0C1 ABC, R0C2 DEF.
  - R1C0 GHI, R1C1 JKL, R1C2 MNO.
  - R2C0 PQRS, R2C1 TUV, R2C2 WXYZ.
  - R3C0: submit letter. R3C1: cancel. R3C2: submit word.
- Scanner FSM states:
  - SCAN: rotate `col` C0→C1→C2→C0, holding each column for `SCAN_CYCLES`. If `row` is non-zero with exactly one bit set, latch the key code, freeze `col`, go to DEBOUNCE.
  - DEBOUNCE: count cycles while `row` equals the latched pattern.
    - Any mismatch → back to SCAN; the counter clears and column rotation resumes from the frozen column.
    - Count reaches `DEBOUNCE_CYCLES` → fire one press event, go to HELD.
  - HELD: wait for `row == 0`, then go to RELEASE.
  - RELEASE: count cycles of `row == 0`.
    - Reaching `DEBOUNCE_CYCLES` → SCAN.
    - Any non-zero row → back to HELD. No second event is generated.
- Multi-row patterns (more than one bit set) are ignored in SCAN, with no event. R0C0 produces an event with no effect.
- Multi-tap, applied on each press event:
  - Letter key equal to the last key: tap index = (index+1) mod group size (3, or 4 for PQRS/WXYZ).
  - Otherwise: index = 0 and last key = new key.
  - `cur_letter` = group base + index (uppercase ASCII); `letter_valid` = 1.
- Submit letter:
  - With `letter_valid`: `letter_strobe`=1 with the letter, then clear the selection (`cur_letter`=0, `letter_valid`=0, last key = none).
  - Without: `error` pulse.
- Cancel: clear the selection; no strobe.
- Submit word:
  - With `letter_valid`=0: `word_strobe` pulse.
  - With a pending selection: `error` pulse, no `word_strobe`, selection kept.
- Pressing the same letter key again after a submit restarts at index 0, because last key was cleared.

## Timing
- Reset values: `col`=3'b001, `cur_letter`=8'h00, `letter_valid`=0, all strobes 0, FSM=SCAN, all counters 0, last key = none.
- Press event is internal, in the cycle the debounce count hits `DEBOUNCE_CYCLES`. Outputs update on the next rising edge, so visible latency is `DEBOUNCE_CYCLES`+1 cycles after the row pattern first matches.
- Strobes are exactly one cycle wide. At most one strobe per press, since only one event exists per press.
- Tap counter width is 2 bits. Scan and debounce counters are sized with `$clog2` of their parameter and saturate; they never wrap.
- Reset asserted mid-press: immediate return to reset values. A key still held at release of reset is detected fresh from SCAN.

## Structure
- `hangman_pkg` holds:
  - the key-code enum (`KEY_ABC` … `KEY_WXYZ`, `KEY_SUBMIT_LETTER`, `KEY_CANCEL`, `KEY_SUBMIT_WORD`, `KEY_NONE`);
  - group base ASCII and group-size constants;
  - the scanner state enum.
- Sub-module `keypad_scanner`: scan, debounce and release FSM, producing a `key_code` plus a one-cycle `press` pulse. The top level holds the multi-tap and submit logic.

## Test plan
All scenarios use `SCAN_CYCLES`=4 and `DEBOUNCE_CYCLES`=8.
- Reset, no keys → `col` cycles 001→010→100 every 4 cycles; all outputs 0.
- Hold `row`=4'b1000 while C1 is driven, for 20 cycles, then release for 20 → `cur_letter`=8'h41 ('A'), `letter_valid`=1; exactly one event.
- R2C0 pressed 5 times with full releases → P,Q,R,S,P (8'h50,51,52,53,50).
- R1C1 ×3, then R3C0 → `letter_strobe` for one cycle with `cur_letter`=8'h4C ('L'), then `cur_letter`=0; R3C0 again → `error` pulse, no strobe.
- A 5-cycle glitch on `row`, or `row`=4'b1100 → no event. R0C1 then R3C2 → `error`, 'A' kept; R3C1 then R3C2 → `word_strobe`.
- `nRst` low while in DEBOUNCE → outputs return to reset values asynchronously; the key held through reset deassertion yields one event.

Source files
------------

// File: rtl/hangman_pkg.sv
// Shared types for the hangman keypad front end: key codes, scanner states,
// letter-group tables and the row/column decode helpers.
package hangman_pkg;

  typedef enum logic [3:0] {
    KEY_ABC           = 4'd0,
    KEY_DEF           = 4'd1,
    KEY_GHI           = 4'd2,
    KEY_JKL           = 4'd3,
    KEY_MNO           = 4'd4,
    KEY_PQRS          = 4'd5,
    KEY_TUV           = 4'd6,
    KEY_WXYZ          = 4'd7,
    KEY_SUBMIT_LETTER = 4'd8,
    KEY_CANCEL        = 4'd9,
    KEY_SUBMIT_WORD   = 4'd10,
    KEY_NONE          = 4'd15
  } key_code_t;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2,
    ST_RELEASE  = 2'd3
  } scan_state_t;

  localparam logic [7:0] ASCII_NONE      = 8'h00;
  localparam logic [2:0] GROUP_SIZE_STD  = 3'd3;
  localparam logic [2:0] GROUP_SIZE_WIDE = 3'd4;

  function automatic logic is_letter_key(input key_code_t k);
    return (k <= KEY_WXYZ);
  endfunction

  function automatic logic [7:0] group_base(input key_code_t k);
    logic [7:0] base;
    case (k)
      KEY_ABC:  base = 8'h41;
      KEY_DEF:  base = 8'h44;
      KEY_GHI:  base = 8'h47;
      KEY_JKL:  base = 8'h4A;
      KEY_MNO:  base = 8'h4D;
      KEY_PQRS: base = 8'h50;
      KEY_TUV:  base = 8'h54;
      KEY_WXYZ: base = 8'h57;
      default:  base = ASCII_NONE;
    endcase
    return base;
  endfunction

  function automatic logic [2:0] group_size(input key_code_t k);
    return (k == KEY_PQRS || k == KEY_WXYZ) ? GROUP_SIZE_WIDE : GROUP_SIZE_STD;
  endfunction

  function automatic logic [1:0] col_to_idx(input logic [2:0] col);
    logic [1:0] idx;
    case (col)
      3'b010:  idx = 2'd1;
      3'b100:  idx = 2'd2;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  // Linear key position r*3+c; position 0 (R0C0) has no function.
  function automatic key_code_t decode_key(input logic [3:0] row, input logic [1:0] cidx);
    logic [1:0] ridx;
    logic [3:0] pos;
    case (row)
      4'b0100: ridx = 2'd1;
      4'b0010: ridx = 2'd2;
      4'b0001: ridx = 2'd3;
      default: ridx = 2'd0;
    endcase
    pos = 4'(ridx) * 4'd3 + 4'(cidx);
    if (pos == 4'd0) return KEY_NONE;
    return key_code_t'(pos - 4'd1);
  endfunction

endpackage

// File: rtl/keypad_scanner.sv
// Column scanner with press and release debounce; emits one registered press
// pulse per physical key press together with the decoded key code.
module keypad_scanner
  import hangman_pkg::*;
#(
  parameter int SCAN_CYCLES     = 4,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic [3:0] row,
  output logic [2:0] col,
  output key_code_t  key_code,
  output logic       press
);

  localparam int SW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_CYCLES - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);

  scan_state_t   state_q, state_d;
  logic [2:0]    col_q, col_d;
  logic [SW-1:0] scan_cnt_q, scan_cnt_d;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  logic [3:0]    row_lat_q, row_lat_d;
  key_code_t     key_q, key_d;
  logic          press_q, press_d;

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    scan_cnt_d = scan_cnt_q;
    deb_cnt_d  = deb_cnt_q;
    row_lat_d  = row_lat_q;
    key_d      = key_q;
    press_d    = 1'b0;
    case (state_q)
      ST_SCAN: begin
        // A detected key freezes the column so the row pattern stays valid.
        if ($onehot(row)) begin
          row_lat_d = row;
          key_d     = decode_key(row, col_to_idx(col_q));
          deb_cnt_d = '0;
          state_d   = ST_DEBOUNCE;
        end else if (scan_cnt_q == SCAN_LAST) begin
          scan_cnt_d = '0;
          col_d      = {col_q[1:0], col_q[2]};
        end else begin
          scan_cnt_d = scan_cnt_q + 1'b1;
        end
      end
      ST_DEBOUNCE: begin
        if (row != row_lat_q) begin
          deb_cnt_d = '0;
          state_d   = ST_SCAN;
        end else if (deb_cnt_q == DEB_LAST) begin
          deb_cnt_d = '0;
          press_d   = 1'b1;
          state_d   = ST_HELD;
        end else begin
          deb_cnt_d = deb_cnt_q + 1'b1;
        end
      end
      ST_HELD: begin
        if (row == 4'b0000) begin
          deb_cnt_d = '0;
          state_d   = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        // Bounce during release returns to HELD without a second event.
        if (row != 4'b0000) begin
          deb_cnt_d = '0;
          state_d   = ST_HELD;
        end else if (deb_cnt_q == DEB_LAST) begin
          deb_cnt_d = '0;
          state_d   = ST_SCAN;
        end else begin
          deb_cnt_d = deb_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_SCAN;
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q    <= ST_SCAN;
      col_q      <= 3'b001;
      scan_cnt_q <= '0;
      deb_cnt_q  <= '0;
      row_lat_q  <= 4'b0000;
      key_q      <= KEY_NONE;
      press_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      scan_cnt_q <= scan_cnt_d;
      deb_cnt_q  <= deb_cnt_d;
      row_lat_q  <= row_lat_d;
      key_q      <= key_d;
      press_q    <= press_d;
    end
  end

  assign col      = col_q;
  assign key_code = key_q;
  assign press    = press_q;

endmodule

// File: rtl/keypad_letter_entry.sv
// Keypad front end for one hangman player: multi-tap letter selection and
// letter/word submit strobes built on top of the debounced scanner.
module keypad_letter_entry
  import hangman_pkg::*;
#(
  parameter int SCAN_CYCLES     = 4,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic [3:0] row,
  output logic [2:0] col,
  output logic [7:0] cur_letter,
  output logic       letter_valid,
  output logic       letter_strobe,
  output logic       word_strobe,
  output logic       error
);

  key_code_t  key_code;
  logic       press;

  key_code_t  last_key_q, last_key_d;
  logic [1:0] tap_q, tap_d;
  logic [7:0] cur_letter_q, cur_letter_d;
  logic       letter_valid_q, letter_valid_d;
  logic       letter_strobe_q, letter_strobe_d;
  logic       word_strobe_q, word_strobe_d;
  logic       error_q, error_d;

  keypad_scanner #(
    .SCAN_CYCLES     (SCAN_CYCLES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_scan (
    .clk      (clk),
    .nRst     (nRst),
    .row      (row),
    .col      (col),
    .key_code (key_code),
    .press    (press)
  );

  always_comb begin
    last_key_d      = last_key_q;
    tap_d           = tap_q;
    cur_letter_d    = cur_letter_q;
    letter_valid_d  = letter_valid_q;
    letter_strobe_d = 1'b0;
    word_strobe_d   = 1'b0;
    error_d         = 1'b0;

    // The submitted letter stays visible for the strobe cycle, then clears.
    if (letter_strobe_q) begin
      last_key_d     = KEY_NONE;
      tap_d          = 2'd0;
      cur_letter_d   = ASCII_NONE;
      letter_valid_d = 1'b0;
    end

    if (press) begin
      if (is_letter_key(key_code)) begin
        if (key_code == last_key_d) begin
          tap_d = ({1'b0, tap_d} == group_size(key_code) - 3'd1) ? 2'd0 : tap_d + 2'd1;
        end else begin
          tap_d = 2'd0;
        end
        last_key_d     = key_code;
        cur_letter_d   = group_base(key_code) + {6'b0, tap_d};
        letter_valid_d = 1'b1;
      end else begin
        case (key_code)
          KEY_SUBMIT_LETTER: begin
            if (letter_valid_d) letter_strobe_d = 1'b1;
            else                error_d         = 1'b1;
          end
          KEY_CANCEL: begin
            last_key_d     = KEY_NONE;
            tap_d          = 2'd0;
            cur_letter_d   = ASCII_NONE;
            letter_valid_d = 1'b0;
          end
          KEY_SUBMIT_WORD: begin
            if (letter_valid_d) error_d       = 1'b1;
            else                word_strobe_d = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      last_key_q      <= KEY_NONE;
      tap_q           <= 2'd0;
      cur_letter_q    <= ASCII_NONE;
      letter_valid_q  <= 1'b0;
      letter_strobe_q <= 1'b0;
      word_strobe_q   <= 1'b0;
      error_q         <= 1'b0;
    end else begin
      last_key_q      <= last_key_d;
      tap_q           <= tap_d;
      cur_letter_q    <= cur_letter_d;
      letter_valid_q  <= letter_valid_d;
      letter_strobe_q <= letter_strobe_d;
      word_strobe_q   <= word_strobe_d;
      error_q         <= error_d;
    end
  end

  assign cur_letter    = cur_letter_q;
  assign letter_valid  = letter_valid_q;
  assign letter_strobe = letter_strobe_q;
  assign word_strobe   = word_strobe_q;
  assign error         = error_q;

endmodule

// File: tb/tb_keypad_letter_entry.sv
// Directed bench for keypad_letter_entry: a behavioural keypad drives rows
// from the scanned column; strobe pulses are counted by a negedge monitor.
module tb_keypad_letter_entry;
  import hangman_pkg::*;

  logic       clk;
  logic       nRst;
  logic [3:0] row;
  logic [2:0] col;
  logic [7:0] cur_letter;
  logic       letter_valid;
  logic       letter_strobe;
  logic       word_strobe;
  logic       error;

  logic       key_down;
  logic [1:0] key_r;
  logic [1:0] key_c;
  logic       override_en;
  logic [3:0] override_row;

  int checks;
  int errors;
  int ls_cnt;
  int ws_cnt;
  int err_cnt;
  logic [7:0] ls_letter;

  keypad_letter_entry #(
    .SCAN_CYCLES     (4),
    .DEBOUNCE_CYCLES (8)
  ) u_dut (
    .clk           (clk),
    .nRst          (nRst),
    .row           (row),
    .col           (col),
    .cur_letter    (cur_letter),
    .letter_valid  (letter_valid),
    .letter_strobe (letter_strobe),
    .word_strobe   (word_strobe),
    .error         (error)
  );

  // clock / keypad model
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign row = override_en ? override_row :
               (key_down && col[key_c]) ? (4'b1000 >> key_r) : 4'b0000;

  // strobe monitor
  always @(negedge clk) begin
    if (letter_strobe) begin
      ls_cnt++;
      ls_letter = cur_letter;
    end
    if (word_strobe) ws_cnt++;
    if (error) err_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic press_key(input logic [1:0] r, input logic [1:0] c);
    key_r    = r;
    key_c    = c;
    key_down = 1'b1;
    repeat (40) @(negedge clk);
    key_down = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  initial begin
    int  exp_ls;
    int  exp_ws;
    int  exp_err;
    logic found;
    checks = 0; errors = 0; ls_cnt = 0; ws_cnt = 0; err_cnt = 0; ls_letter = 8'h00;
    exp_ls = 0; exp_ws = 0; exp_err = 0;
    nRst = 1'b0; key_down = 1'b0; key_r = 2'd0; key_c = 2'd0;
    override_en = 1'b0; override_row = 4'b0000;

    repeat (3) @(negedge clk);
    nRst = 1'b1;
    check("rst_col", 32'(col), 32'h1);
    check("rst_letter", 32'(cur_letter), 32'h0);
    check("rst_valid", 32'(letter_valid), 32'h0);
    check("rst_lstrobe", 32'(letter_strobe), 32'h0);
    check("rst_wstrobe", 32'(word_strobe), 32'h0);
    check("rst_error", 32'(error), 32'h0);

    repeat (4) @(negedge clk);
    check("scan_c1", 32'(col), 32'h2);
    repeat (4) @(negedge clk);
    check("scan_c2", 32'(col), 32'h4);
    repeat (4) @(negedge clk);
    check("scan_c0", 32'(col), 32'h1);

    press_key(2'd0, 2'd1);
    check("abc_letter", 32'(cur_letter), 32'h41);
    check("abc_valid", 32'(letter_valid), 32'h1);

    press_key(2'd2, 2'd0);
    check("pqrs_1", 32'(cur_letter), 32'h50);
    press_key(2'd2, 2'd0);
    check("pqrs_2", 32'(cur_letter), 32'h51);
    press_key(2'd2, 2'd0);
    check("pqrs_3", 32'(cur_letter), 32'h52);
    press_key(2'd2, 2'd0);
    check("pqrs_4", 32'(cur_letter), 32'h53);
    press_key(2'd2, 2'd0);
    check("pqrs_wrap", 32'(cur_letter), 32'h50);

    press_key(2'd1, 2'd1);
    press_key(2'd1, 2'd1);
    press_key(2'd1, 2'd1);
    check("jkl_l", 32'(cur_letter), 32'h4C);
    press_key(2'd3, 2'd0);
    exp_ls++;
    check("submit_cnt", 32'(ls_cnt), 32'(exp_ls));
    check("submit_letter", 32'(ls_letter), 32'h4C);
    check("submit_clear", 32'(cur_letter), 32'h0);
    check("submit_invalid", 32'(letter_valid), 32'h0);
    press_key(2'd3, 2'd0);
    exp_err++;
    check("empty_submit_err", 32'(err_cnt), 32'(exp_err));
    check("empty_submit_nostrobe", 32'(ls_cnt), 32'(exp_ls));

    // 5-cycle glitch on R1 and a two-row pattern: neither may register.
    override_en = 1'b1; override_row = 4'b0100;
    repeat (5) @(negedge clk);
    override_row = 4'b0000;
    repeat (20) @(negedge clk);
    check("glitch_letter", 32'(cur_letter), 32'h0);
    override_row = 4'b1100;
    repeat (20) @(negedge clk);
    override_row = 4'b0000;
    repeat (20) @(negedge clk);
    override_en = 1'b0;
    check("multirow_letter", 32'(cur_letter), 32'h0);
    check("multirow_valid", 32'(letter_valid), 32'h0);
    check("glitch_no_err", 32'(err_cnt), 32'(exp_err));

    press_key(2'd0, 2'd1);
    press_key(2'd0, 2'd0);
    check("r0c0_noeffect", 32'(cur_letter), 32'h41);
    press_key(2'd3, 2'd2);
    exp_err++;
    check("word_pending_err", 32'(err_cnt), 32'(exp_err));
    check("word_pending_nows", 32'(ws_cnt), 32'(exp_ws));
    check("word_pending_kept", 32'(cur_letter), 32'h41);
    check("word_pending_valid", 32'(letter_valid), 32'h1);
    press_key(2'd3, 2'd1);
    check("cancel_letter", 32'(cur_letter), 32'h0);
    check("cancel_valid", 32'(letter_valid), 32'h0);
    check("cancel_no_strobe", 32'(ls_cnt), 32'(exp_ls));
    press_key(2'd3, 2'd2);
    exp_ws++;
    check("word_strobe_cnt", 32'(ws_cnt), 32'(exp_ws));
    check("word_no_err", 32'(err_cnt), 32'(exp_err));

    press_key(2'd0, 2'd1);
    press_key(2'd3, 2'd0);
    exp_ls++;
    check("submit_a_cnt", 32'(ls_cnt), 32'(exp_ls));
    check("submit_a_letter", 32'(ls_letter), 32'h41);
    press_key(2'd0, 2'd1);
    check("restart_index", 32'(cur_letter), 32'h41);

    // Reset while the scanner is debouncing MNO; key stays down through reset.
    key_r = 2'd1; key_c = 2'd2; key_down = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (u_dut.u_scan.state_q == ST_DEBOUNCE) found = 1'b1;
    end
    check("debounce_reached", 32'(found), 32'h1);
    #3 nRst = 1'b0;
    #1;
    check("async_col", 32'(col), 32'h1);
    check("async_letter", 32'(cur_letter), 32'h0);
    check("async_valid", 32'(letter_valid), 32'h0);
    repeat (2) @(negedge clk);
    nRst = 1'b1;
    repeat (40) @(negedge clk);
    key_down = 1'b0;
    repeat (20) @(negedge clk);
    check("post_reset_m", 32'(cur_letter), 32'h4D);
    check("post_reset_valid", 32'(letter_valid), 32'h1);
    check("final_ls", 32'(ls_cnt), 32'(exp_ls));
    check("final_ws", 32'(ws_cnt), 32'(exp_ws));
    check("final_err", 32'(err_cnt), 32'(exp_err));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
